// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises 32-bit LSU and ICache requests onto the 8-bit RAM/IO bus.
// Requests are split into 1/2/4 little-endian byte cycles. The assembled result
// comes back with a one-cycle done pulse. IO stores are held off while the IO
// buffer is full, and in-flight reads are dropped on a ROB rollback.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        lsu_valid_in,
    input  logic        lsu_rw_in,
    input  logic [1:0]  lsu_size_in,
    input  logic [31:0] lsu_addr_in,
    input  logic [31:0] lsu_wdata_in,
    output logic        lsu_done_out,
    output logic [31:0] lsu_rdata_out,
    input  logic        ic_valid_in,
    input  logic [31:0] ic_addr_in,
    output logic        ic_done_out,
    output logic [31:0] ic_inst_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        roll_back_flag_from_rob
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_ic_q, src_ic_d;
    logic [31:0] result_q, result_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        lsu_done_q, lsu_done_d;
    logic        ic_done_q, ic_done_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic [31:0] ic_inst_q, ic_inst_d;

    logic        io_hold;
    logic        take_lsu;
    logic        take_ic;
    logic [2:0]  k;
    logic [31:0] addr_k;
    logic [31:0] result_mrg;

    // Byte count for a request size; the reserved encoding 11 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   size_to_n = 3'd1;
            2'b01:   size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    // Little-endian byte lane i of a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    // An IO store (addr[17:16]==11) waits for buffer space; LSU keeps priority while it waits.
    assign io_hold  = lsu_valid_in && !lsu_rw_in && (lsu_addr_in[17:16] == 2'b11) && io_buffer_full;
    assign take_lsu = !roll_back_flag_from_rob && lsu_valid_in && !io_hold;
    assign take_ic  = !roll_back_flag_from_rob && !lsu_valid_in && ic_valid_in;

    // k is the index of the edge inside the transfer; addr+k wraps modulo 2^32.
    assign k      = {1'b0, idx_q} + 3'd1;
    assign addr_k = addr_q + {29'd0, k};

    // Drop the incoming byte into lane idx of the partial result.
    always_comb begin
        result_mrg = result_q;
        case (idx_q)
            2'd0:    result_mrg[7:0]   = mem_din;
            2'd1:    result_mrg[15:8]  = mem_din;
            2'd2:    result_mrg[23:16] = mem_din;
            default: result_mrg[31:24] = mem_din;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_q <= IDLE;
        else if (rdy_in)
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_lsu)
                    state_d = lsu_rw_in ? READ : WRITE;
                else if (take_ic)
                    state_d = READ;
            end
            READ: begin
                if (roll_back_flag_from_rob)
                    state_d = IDLE;
                else if (k == n_q)
                    state_d = DONE;
            end
            WRITE: begin
                if (k == n_q)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and bus/requester outputs.
    always_comb begin
        idx_d       = idx_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        src_ic_d    = src_ic_q;
        result_d    = result_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        lsu_done_d  = 1'b0;
        ic_done_d   = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        ic_inst_d   = ic_inst_q;
        case (state_q)
            IDLE: begin
                if (take_lsu) begin
                    addr_d   = lsu_addr_in;
                    wdata_d  = lsu_wdata_in;
                    n_d      = size_to_n(lsu_size_in);
                    src_ic_d = 1'b0;
                    idx_d    = 2'd0;
                    result_d = 32'd0;
                    mem_a_d  = lsu_addr_in;
                    if (!lsu_rw_in) begin
                        mem_dout_d = lsu_wdata_in[7:0];
                        mem_wr_d   = 1'b1;
                        // A single-byte store completes in its only write cycle.
                        lsu_done_d = (lsu_size_in == 2'b00);
                    end
                end else if (take_ic) begin
                    addr_d   = ic_addr_in;
                    wdata_d  = 32'd0;
                    n_d      = 3'd4;
                    src_ic_d = 1'b1;
                    idx_d    = 2'd0;
                    result_d = 32'd0;
                    mem_a_d  = ic_addr_in;
                end
            end
            READ: begin
                // On rollback the partial result is simply abandoned.
                if (!roll_back_flag_from_rob) begin
                    result_d = result_mrg;
                    if (k == n_q) begin
                        if (src_ic_q) begin
                            ic_done_d = 1'b1;
                            ic_inst_d = result_mrg;
                        end else begin
                            lsu_done_d  = 1'b1;
                            lsu_rdata_d = result_mrg;
                        end
                    end else begin
                        mem_a_d = addr_k;
                        idx_d   = k[1:0];
                    end
                end
            end
            WRITE: begin
                // Stores are committed, so rollback is ignored here.
                if (k != n_q) begin
                    mem_a_d    = addr_k;
                    mem_dout_d = byte_sel(wdata_q, k[1:0]);
                    mem_wr_d   = 1'b1;
                    idx_d      = k[1:0];
                    lsu_done_d = ((k + 3'd1) == n_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_q       <= 2'd0;
            n_q         <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            src_ic_q    <= 1'b0;
            result_q    <= 32'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            lsu_done_q  <= 1'b0;
            ic_done_q   <= 1'b0;
            lsu_rdata_q <= 32'd0;
            ic_inst_q   <= 32'd0;
        end else if (rdy_in) begin
            idx_q       <= idx_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            src_ic_q    <= src_ic_d;
            result_q    <= result_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            lsu_done_q  <= lsu_done_d;
            ic_done_q   <= ic_done_d;
            lsu_rdata_q <= lsu_rdata_d;
            ic_inst_q   <= ic_inst_d;
        end
    end

    // A held write cycle must not repeat on the bus while stalled.
    assign mem_wr        = mem_wr_q & rdy_in;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign lsu_done_out  = lsu_done_q;
    assign ic_done_out   = ic_done_q;
    assign lsu_rdata_out = lsu_rdata_q;
    assign ic_inst_out   = ic_inst_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the 8-bit-wide unified RAM/IO bus and the two 32-bit requesters: the LSU (data loads/stores) and the instruction cache (word fetches). It accepts one request at a time, serialises it into 1/2/4 byte-wide bus cycles in little-endian order, and returns the assembled result with a one-cycle done pulse. It also holds off IO writes while the IO buffer is full, and drops speculative reads on ROB rollback.

## Interface
- No parameters.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, all state holds.
- lsu_valid_in  input  1  LSU request; held high until lsu_done_out.
- lsu_rw_in  input  1  1 = read, 0 = write.
- lsu_size_in  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- lsu_addr_in  input  32  byte address.
- lsu_wdata_in  input  32  store data; low `size` bytes are used.
- lsu_done_out  output  1  one-cycle completion pulse.
- lsu_rdata_out  output  32  read data, zero-filled above size; valid while lsu_done_out is high.
- ic_valid_in  input  1  fetch request; held until ic_done_out.
- ic_addr_in  input  32  fetch address; always a 4-byte read.
- ic_done_out  output  1  one-cycle completion pulse.
- ic_inst_out  output  32  fetched word; valid while ic_done_out is high.
- mem_din  input  8  RAM/IO read byte; valid the cycle after its address is driven.
- mem_dout  output  8  write byte.
- mem_a  output  32  bus address.
- mem_wr  output  1  1 = write this cycle.
- io_buffer_full  input  1  IO output buffer full.
- roll_back_flag_from_rob  input  1  mispredict flush.

## Operation
- States:
  - IDLE
  - READ
  - WRITE
  - DONE
- Byte counter `idx` is 0..3. `n` (1, 2 or 4) is latched from the request size at accept.
- IDLE arbitration: LSU has fixed priority over ICache. The ICache is served only when lsu_valid_in is low.
- IO hold: an LSU write to an address with addr[17:16]==2'b11 is not accepted while io_buffer_full is high. The ICache is not served in that cycle either, because the LSU still has priority.
- Accept edge (E0):
  - latch addr, wdata, n and source;
  - set idx=0;
  - drive mem_a=addr;
  - for a write, also drive mem_dout=wdata[7:0] and mem_wr=1;
  - go to READ or WRITE.
- READ, at edge Ek (k ≥ 1):
  - capture mem_din into result byte k-1;
  - if k < n, drive mem_a=addr+k;
  - if k == n, assert the done pulse for the source with the full result and go to DONE.
  - mem_wr stays 0 throughout.
- WRITE, at edge Ek (1 ≤ k < n): drive mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
- WRITE done: lsu_done_out is asserted during the cycle of the last byte, which is the cycle after E(n-1).
- DONE: lasts one cycle.
  - done pulses are low;
  - mem_wr=0;
  - mem_a holds its value;
  - go to IDLE.
  - Requesters must drop valid at the edge that ends their done cycle.
- Address arithmetic: addr+k is 32-bit and wraps modulo 2^32 with no fault.
- Rollback: roll_back_flag_from_rob high at an edge in READ (either source) aborts the read.
  - state goes to IDLE;
  - no done pulse;
  - mem_wr=0;
  - the partial result is discarded.
  - In IDLE, a pending request is not accepted on that edge.
  - WRITE is never aborted: stores are committed.
- rdy_in low: all registers hold. mem_wr is gated to 0 combinationally so that no duplicate write occurs.

## Timing
- Reset (async assert):
  - state=IDLE;
  - mem_wr=0, mem_a=0, mem_dout=0;
  - lsu_done_out=0, ic_done_out=0;
  - lsu_rdata_out=0, ic_inst_out=0;
  - idx=0.
- Reset has effect immediately, including mid-operation. A write cut short by reset is left partial; that is acceptable.
- Read of n bytes: the done pulse is visible in the cycle after edge En, i.e. n+1 cycles after valid is first sampled in IDLE (word: 5).
- Write of n bytes: the done pulse coincides with the last mem_wr cycle (word: 4 cycles, byte: 1 cycle).
- Back-to-back throughput: one DONE bubble, so the next request is accepted at the edge after DONE at the earliest.
- Done pulses are exactly one cycle wide. lsu_done_out and ic_done_out are never high together.

## Test plan
- LSU word read at 0x100, RAM bytes 11,22,33,44 → bus addresses 0x100..0x103 on consecutive cycles, mem_wr=0, lsu_rdata_out=0x44332211 with a one-cycle done pulse 5 cycles after accept.
- LSU byte write 0xAABBCCDD to 0x204 → a single cycle with mem_a=0x204, mem_dout=0xDD, mem_wr=1; done in the same cycle; nothing else written.
- LSU read and ICache fetch both valid in IDLE → LSU served first. The ICache fetch starts after DONE, and ic_inst_out returns the correct word.
- ICache fetch with rollback at E2 → no ic_done_out, IDLE next cycle, and a new fetch then completes normally. Rollback during an LSU half write → both bytes are written and done is asserted.
- LSU write to 0x30000 with io_buffer_full=1 for 3 cycles → no mem_wr during those cycles; accepted on the first edge after full drops; a single mem_wr of the low byte.
- rst_in driven low at E2 of a word read → all outputs at reset values immediately, and no done pulse after release. rdy_in low for 2 cycles mid-read → the completion cycle shifts by 2 and data is still correct.
